// File: rtl/datapath_pkg.sv
// Shared datapath definitions: shift opcodes, default widths and the shift-op FIFO entry layout.
package datapath_pkg;

  localparam int DP_WIDTH  = 16;
  localparam int DP_TAG_W  = 3;
  localparam int SH_CTRL_W = 2;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2,
    SH_ROR = 2'd3
  } sh_op_e;

  // Entry layout at default widths; parameterised users pack the same field order flat.
  typedef struct packed {
    sh_op_e                ctrl;
    logic [DP_WIDTH-1:0]   shamt;
    logic [DP_WIDTH-1:0]   data;
    logic [DP_TAG_W-1:0]   tag;
  } sh_entry_t;

  function automatic int entry_width(input int w, input int t);
    return SH_CTRL_W + 2 * w + t;
  endfunction

endpackage

// File: rtl/op_fifo2.sv
// Two-entry synchronous FIFO with flush; 1-bit pointers wrap modulo 2, occupancy 0..2.
module op_fifo2 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata,
  output logic          o_full,
  output logic          o_empty
);

  logic [DW-1:0] r_mem [2];
  logic          r_wptr;
  logic          r_rptr;
  logic [1:0]    r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign o_rdata = r_mem[r_rptr];

  assign w_push = i_push && !o_full && !i_flush;
  assign w_pop  = i_pop && !o_empty && !i_flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else if (i_flush) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/shifter.sv
// Combinational barrel shifter: logical left/right, arithmetic right and rotate right.
module shifter
  import datapath_pkg::*;
#(
  parameter int WIDTH = DP_WIDTH
) (
  input  logic [1:0]       shiftControl,
  input  logic [WIDTH-1:0] shamt,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] result
);

  localparam logic [WIDTH-1:0] LP_W = WIDTH'(WIDTH);

  // Rotate expects shamt < WIDTH; callers reduce it first.
  always_comb begin
    result = data;
    case (sh_op_e'(shiftControl))
      SH_SLL:  result = data << shamt;
      SH_SRL:  result = data >> shamt;
      SH_SRA:  result = $signed(data) >>> shamt;
      SH_ROR:  result = (data >> shamt) | (data << (LP_W - shamt));
      default: result = data;
    endcase
  end

endmodule

// File: rtl/shift_ex_stage.sv
// Execute stage for shift micro-ops: 2-deep input buffer, shifter with out-of-range
// correction, and a result register held until writeback accepts it.
module shift_ex_stage
  import datapath_pkg::*;
#(
  parameter int WIDTH = DP_WIDTH,
  parameter int TAG_W = DP_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_ctrl,
  input  logic [WIDTH-1:0] in_shamt,
  input  logic [WIDTH-1:0] in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [15:0]      op_count
);

  localparam int               ENTRY_W = entry_width(WIDTH, TAG_W);
  localparam logic [WIDTH-1:0] LP_W    = WIDTH'(WIDTH);

  logic [ENTRY_W-1:0] w_wdata;
  logic [ENTRY_W-1:0] w_head;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic               w_push;
  logic               w_load;

  logic [1:0]         w_head_ctrl;
  logic [WIDTH-1:0]   w_head_shamt;
  logic [WIDTH-1:0]   w_head_data;
  logic [TAG_W-1:0]   w_head_tag;
  logic [WIDTH-1:0]   w_sh_shamt;
  logic [WIDTH-1:0]   w_sh_result;
  logic [WIDTH-1:0]   w_fixed;
  logic               w_oor;

  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_result;
  logic [TAG_W-1:0]   r_out_tag;
  logic [15:0]        r_op_count;

  // in_ready depends only on registered occupancy, never on out_ready.
  assign in_ready = !w_fifo_full;
  assign w_push   = in_valid && !w_fifo_full && !flush;
  assign w_load   = !w_fifo_empty && (!r_out_valid || out_ready) && !flush;
  assign w_wdata  = {in_ctrl, in_shamt, in_data, in_tag};

  op_fifo2 #(
    .DW (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_push  (w_push),
    .i_pop   (w_load),
    .i_wdata (w_wdata),
    .o_rdata (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign {w_head_ctrl, w_head_shamt, w_head_data, w_head_tag} = w_head;

  assign w_oor      = (w_head_shamt >= LP_W);
  assign w_sh_shamt = (w_head_ctrl == SH_ROR) ? (w_head_shamt % LP_W) : w_head_shamt;

  shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .shiftControl (w_head_ctrl),
    .shamt        (w_sh_shamt),
    .data         (w_head_data),
    .result       (w_sh_result)
  );

  // Large amounts are pinned explicitly rather than trusting the shifter's overflow behaviour.
  always_comb begin
    w_fixed = w_sh_result;
    if (w_oor) begin
      case (sh_op_e'(w_head_ctrl))
        SH_SLL:  w_fixed = '0;
        SH_SRL:  w_fixed = '0;
        SH_SRA:  w_fixed = {WIDTH{w_head_data[WIDTH-1]}};
        default: w_fixed = w_sh_result;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_tag    <= '0;
      r_op_count   <= 16'd0;
    end else begin
      if (r_out_valid && out_ready) r_op_count <= r_op_count + 16'd1;
      if (flush) begin
        r_out_valid <= 1'b0;
      end else if (w_load) begin
        r_out_valid  <= 1'b1;
        r_out_result <= w_fixed;
        r_out_tag    <= w_head_tag;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_tag    = r_out_tag;
  assign op_count   = r_op_count;

endmodule

// File: tb/tb_shift_ex_stage.sv
// Self-checking bench for shift_ex_stage: vector table plus directed handshake, flush and reset sequences.
module tb_shift_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  in_ctrl;
  logic [15:0] in_shamt, in_data, out_result, op_count;
  logic [2:0]  in_tag, out_tag;

  shift_ex_stage #(.WIDTH(16), .TAG_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ctrl    (in_ctrl),
    .in_shamt   (in_shamt),
    .in_data    (in_data),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ctrl;
    logic [15:0] shamt;
    logic [15:0] data;
    logic [2:0]  tag;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [15:0] result;
    logic [2:0]  tag;
  } sb_t;

  vec_t        vecs[14];
  sb_t         sb[$];
  int          n_checks = 0;
  int          n_err    = 0;
  logic [15:0] exp_cnt  = 16'd0;
  logic [15:0] cur_exp  = 16'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Bit-by-bit reference: each result bit is picked from its source position.
  function automatic logic [15:0] model(input logic [1:0] c, input logic [15:0] s,
                                        input logic [15:0] d);
    logic [15:0] r;
    int sh;
    sh = int'(s);
    r  = '0;
    for (int i = 0; i < 16; i++) begin
      case (c)
        2'd0:    r[i] = (i - sh >= 0) ? d[i - sh] : 1'b0;
        2'd1:    r[i] = (i + sh < 16) ? d[i + sh] : 1'b0;
        2'd2:    r[i] = (i + sh < 16) ? d[i + sh] : d[15];
        default: r[i] = d[(i + sh) % 16];
      endcase
    end
    return r;
  endfunction

  // Scoreboard bookkeeping for the edge about to happen, then advance to just after it.
  task automatic step();
    sb_t e;
    if (!rst_n) begin
      sb.delete();
      exp_cnt = 16'd0;
    end else begin
      if (out_valid && out_ready) begin
        exp_cnt = exp_cnt + 16'd1;
        if (sb.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_out: got result %0h tag %0d, expected no output",
                   out_result, out_tag);
        end else begin
          e = sb.pop_front();
          chk("out_result", {16'd0, out_result}, {16'd0, e.result});
          chk("out_tag", {29'd0, out_tag}, {29'd0, e.tag});
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back('{result: cur_exp, tag: in_tag});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] c, input logic [15:0] s, input logic [15:0] d,
                       input logic [2:0] t, input logic [15:0] e);
    in_valid = 1'b1;
    in_ctrl  = c;
    in_shamt = s;
    in_data  = d;
    in_tag   = t;
    cur_exp  = e;
  endtask

  task automatic push_op(input logic [1:0] c, input logic [15:0] s, input logic [15:0] d,
                         input logic [2:0] t, input logic [15:0] e);
    logic acc;
    acc = 1'b0;
    drive(c, s, d, t, e);
    for (int w = 0; w < 20 && !acc; w++) begin
      acc = in_ready;
      step();
    end
    in_valid = 1'b0;
    chk("push_accepted", {31'd0, acc}, 32'd1);
  endtask

  task automatic drain();
    for (int w = 0; w < 40 && (sb.size() != 0 || out_valid); w++) step();
    chk("drain_done", {31'd0, (sb.size() == 0 && !out_valid)}, 32'd1);
    chk("op_count", {16'd0, op_count}, {16'd0, exp_cnt});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    logic acc;
    logic [1:0]  rc;
    logic [15:0] rs, rd;

    vecs[0]  = '{2'd1, 16'd1,      16'h0004, 3'd1, 16'h0002};
    vecs[1]  = '{2'd2, 16'd4,      16'h8000, 3'd2, 16'hF800};
    vecs[2]  = '{2'd0, 16'd20,     16'h00FF, 3'd3, 16'h0000};
    vecs[3]  = '{2'd2, 16'd16,     16'h8001, 3'd4, 16'hFFFF};
    vecs[4]  = '{2'd3, 16'd17,     16'h0001, 3'd5, 16'h8000};
    vecs[5]  = '{2'd3, 16'd4,      16'h1234, 3'd6, 16'h4123};
    vecs[6]  = '{2'd1, 16'd15,     16'h8000, 3'd7, 16'h0001};
    vecs[7]  = '{2'd0, 16'd15,     16'h0001, 3'd0, 16'h8000};
    vecs[8]  = '{2'd2, 16'd15,     16'h7FFF, 3'd1, 16'h0000};
    vecs[9]  = '{2'd3, 16'd0,      16'hABCD, 3'd2, 16'hABCD};
    vecs[10] = '{2'd1, 16'hFFFF,   16'hFFFF, 3'd3, 16'h0000};
    vecs[11] = '{2'd3, 16'd16,     16'hABCD, 3'd4, 16'hABCD};
    vecs[12] = '{2'd2, 16'd3,      16'h4000, 3'd5, 16'h0800};
    vecs[13] = '{2'd0, 16'd0,      16'h1357, 3'd6, 16'h1357};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = 2'd0; in_shamt = 16'd0; in_data = 16'd0; in_tag = 3'd0;
    step();
    step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", {16'd0, out_result}, 32'd0);
    chk("rst_out_tag", {29'd0, out_tag}, 32'd0);
    chk("rst_op_count", {16'd0, op_count}, 32'd0);
    rst_n = 1'b1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single op latency: pushed at edge N, visible after edge N+1.
    out_ready = 1'b1;
    drive(2'd0, 16'd5, 16'h0004, 3'd2, 16'h0080);
    step();
    in_valid = 1'b0;
    chk("lat_not_early", {31'd0, out_valid}, 32'd0);
    step();
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_result", {16'd0, out_result}, 32'h0080);
    chk("lat_tag", {29'd0, out_tag}, 32'd2);
    step();
    chk("lat_count", {16'd0, op_count}, 32'd1);

    // Back-to-back table at full throughput.
    for (int i = 0; i < 14; i++) begin
      chk("tbl_in_ready", {31'd0, in_ready}, 32'd1);
      drive(vecs[i].ctrl, vecs[i].shamt, vecs[i].data, vecs[i].tag, vecs[i].exp);
      step();
      if (i > 0) chk("tbl_no_bubble", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    drain();

    // Backpressure: output stalled, buffer fills, extra offer is refused.
    out_ready = 1'b0;
    push_op(2'd0, 16'd1, 16'h0003, 3'd3, 16'h0006);
    push_op(2'd1, 16'd4, 16'hF0F0, 3'd4, 16'h0F0F);
    push_op(2'd3, 16'd1, 16'h8001, 3'd5, 16'hC000);
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    drive(2'd0, 16'd2, 16'h0001, 3'd6, 16'h0004);
    step();
    step();
    in_valid = 1'b0;
    chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_hold_result", {16'd0, out_result}, 32'h0006);
    chk("bp_hold_tag", {29'd0, out_tag}, 32'd3);
    out_ready = 1'b1;
    drain();

    // Flush with a valid output and two buffered ops.
    out_ready = 1'b0;
    push_op(2'd0, 16'd4, 16'h0001, 3'd1, 16'h0010);
    push_op(2'd1, 16'd1, 16'h0008, 3'd2, 16'h0004);
    push_op(2'd2, 16'd1, 16'h8000, 3'd3, 16'hC000);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_op_count", {16'd0, op_count}, {16'd0, exp_cnt});
    out_ready = 1'b1;
    repeat (4) step();
    chk("flush_no_leak", {31'd0, out_valid}, 32'd0);
    drive(2'd0, 16'd1, 16'h0001, 3'd7, 16'h0002);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    step();
    chk("flush_drop_in", {31'd0, out_valid}, 32'd0);

    // Random traffic checked against the reference model.
    sent = 0;
    for (int cyc = 0; cyc < 400 && sent < 12; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      rc = 2'($urandom_range(0, 3));
      rs = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16, 40)) : 16'($urandom_range(0, 15));
      rd = 16'($urandom);
      drive(rc, rs, rd, 3'($urandom_range(0, 7)), model(rc, rs, rd));
      acc = in_ready;
      step();
      if (acc) sent++;
    end
    in_valid = 1'b0;
    chk("rand_sent", sent, 32'd12);
    out_ready = 1'b1;
    drain();

    // Reset mid-stream overrides a simultaneous flush and handshake.
    out_ready = 1'b0;
    push_op(2'd0, 16'd1, 16'h0101, 3'd5, 16'h0202);
    push_op(2'd1, 16'd1, 16'h0202, 3'd6, 16'h0101);
    out_ready = 1'b1;
    drive(2'd0, 16'd3, 16'h0001, 3'd7, 16'h0008);
    rst_n = 1'b0;
    flush = 1'b1;
    step();
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_out_result", {16'd0, out_result}, 32'd0);
    chk("mid_rst_out_tag", {29'd0, out_tag}, 32'd0);
    chk("mid_rst_op_count", {16'd0, op_count}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    step();
    chk("post_rst_empty", {31'd0, out_valid}, 32'd0);
    push_op(2'd3, 16'd8, 16'h00FF, 3'd4, 16'hFF00);
    drain();
    chk("post_rst_count", {16'd0, op_count}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
